alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing controller wrapped around the team's 64-bit ALU operation set. It accepts one operation at a time over a valid/ready request port. Add, sub and the logic ops complete in one cycle; multiply and divide run as iterative shift-add and restoring-division loops. The result and carry are held on a valid/ready response port until consumed. It sits between the instruction/control logic and the register-file write-back path.

## Interface
- `WIDTH`, 64, operand and result width in bits.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE with `rst` low.
- `req_op` in 4: opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 1000 and, 1001 or, 1010 xor; any other value is treated as add.
- `req_a` in WIDTH: first operand.
- `req_b` in WIDTH: second operand.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_result` out WIDTH: operation result.
- `rsp_carry` out 1: bit WIDTH of `req_a + req_b`, reported for every opcode.
- `busy` out 1: high in EXEC and DONE.

## Operation
- **Accept.** An accept occurs when `req_valid && req_ready`. `req_op`, `req_a` and `req_b` are captured in internal registers at accept. Later changes on the request inputs are ignored.
- **States.**
  - IDLE:
    - On accept of a single-cycle op, go to DONE.
    - On accept of mul, or div when enabled, go to EXEC with `cnt=0`.
  - EXEC: `cnt` increments each cycle. At `cnt==WIDTH-1`, the final iteration completes and the state goes to DONE.
  - DONE: `rsp_valid=1`. On `rsp_ready`, go to IDLE. Otherwise hold.
- **Arithmetic.** All arithmetic is unsigned modulo 2^WIDTH.
  - sub: `a-b` wraps.
  - mul: returns the low WIDTH bits of `a*b`. Each iteration: if the multiplier LSB is 1, add the multiplicand into the accumulator; then shift the multiplicand left by 1 and the multiplier right by 1.
  - div: returns the quotient `floor(a/b)` using restoring division. The partial remainder is WIDTH+1 bits; one quotient bit is produced per cycle, MSB first.
  - Divide by zero: the quotient is all ones; no error flag.
- **Carry.** `rsp_carry` is computed from the captured operands and is registered with the result.
- **Response stability.** While `rsp_valid && !rsp_ready`, `rsp_result` and `rsp_carry` are held stable.
- **No overlap.** No new request is accepted in EXEC or DONE, so there is at most one operation in flight.
- **Reset mid-operation.** An operation in EXEC or DONE is aborted. No response is produced for it, and the block is in IDLE the cycle after `rst` deasserts.
- **Reset values.** IDLE, `rsp_valid=0`, `rsp_result=0`, `rsp_carry=0`, `busy=0`, `cnt=0`. `req_ready=0` while `rst` is high.

## Timing
- Single-cycle ops: accept at edge N; `rsp_valid` and the result are visible after edge N+1 (latency 1).
- mul/div: accept at edge N; `rsp_valid` after edge N+WIDTH+1 (latency 65 at WIDTH=64).
- Response handshake: the response is consumed at the edge where `rsp_valid && rsp_ready`. `req_ready` rises the cycle after consumption.
  - Best-case throughput is one single-cycle op every 2 cycles with `rsp_ready` tied high.
- `req_ready` and `busy` are decoded from the state register only; there is no combinational path from request inputs.
- `rsp_valid` does not depend combinationally on `rsp_ready`.

## Configuration
- `ALU_SEQ_DIV_EN` defined: the restoring divider is compiled in; opcode 0011 runs in EXEC for WIDTH cycles.
- `ALU_SEQ_DIV_EN` undefined: no divider hardware; opcode 0011 falls to the default case (add) with latency 1.
- mul is always present.

## Test plan
- **Add with carry.** add, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> after 1 cycle `rsp_result=0`, `rsp_carry=1`.
- **Sub wrap and logic.** sub, a=3, b=5 -> `rsp_result=0xFFFF_FFFF_FFFF_FFFE`. Then xor, a=0xF0F0, b=0xFF00 -> `0x0FF0`. Both with latency 1.
- **Multiply latency and truncation.** mul, a=0x1_0000_0001, b=0x1_0000_0003 -> `rsp_valid` exactly 65 cycles after accept, result `0x4_0000_0003`. Also a=2^63, b=2 -> result 0.
- **Divide.** With `ALU_SEQ_DIV_EN`: div, a=100, b=7 -> result 14 at latency 65; div, a=5, b=0 -> result all ones. Without the macro: div, a=100, b=7 -> result 107 at latency 1.
- **Backpressure.** Hold `rsp_ready=0` for 10 cycles after `rsp_valid` -> result and carry stay stable and `req_ready` stays 0. Pulse `rsp_ready` -> `req_ready=1` on the next cycle. Changing `req_a` during EXEC does not alter the result.
- **Reset mid-operation.** Assert `rst` at cycle 30 of a mul -> next cycle IDLE, `rsp_valid=0`, `rsp_result=0`. A following add of 2+2 returns 4 normally.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller around a 64-bit ALU: single-cycle add/sub/logic, iterative mul and div.
// Optional restoring divider is compiled in when ALU_SEQ_DIV_EN is defined; otherwise opcode 0011 acts as add.
`timescale 1ns/1ps
module alu_seq_ctrl #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [3:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic [WIDTH:0]     sum_s;
   logic               iter_s;
   logic [WIDTH-1:0]   step_res_s;
`ifdef ALU_SEQ_DIV_EN
   logic               div_q, div_d;
   logic [WIDTH:0]     rem_sh_s;
   logic [WIDTH-1:0]   diff_s;
`endif

   assign sum_s      = {1'b0, req_a} + {1'b0, req_b};
   assign req_ready  = (state_q == S_IDLE) && !rst;
   assign rsp_valid  = valid_q;
   assign rsp_result = result_q;
   assign rsp_carry  = carry_q;
   assign busy       = busy_q;

   // Next-state, datapath iteration and response register updates.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      result_d   = result_q;
      carry_d    = carry_q;
      step_res_s = acc_q;
`ifdef ALU_SEQ_DIV_EN
      div_d      = div_q;
      iter_s     = (req_op == OP_MUL) || (req_op == OP_DIV);
      rem_sh_s   = {acc_q, a_q[WIDTH-1]};
      diff_s     = rem_sh_s[WIDTH-1:0] - b_q;
`else
      iter_s     = (req_op == OP_MUL);
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               carry_d = sum_s[WIDTH];
               cnt_d   = {CNT_W{1'b0}};
               acc_d   = {WIDTH{1'b0}};
`ifdef ALU_SEQ_DIV_EN
               div_d   = (req_op == OP_DIV);
`endif
               if (iter_s) begin
                  state_d = S_EXEC;
               end else begin
                  state_d = S_DONE;
                  case (req_op)
                     OP_SUB:  result_d = req_a - req_b;
                     OP_AND:  result_d = req_a & req_b;
                     OP_OR:   result_d = req_a | req_b;
                     OP_XOR:  result_d = req_a ^ req_b;
                     OP_ADD:  result_d = sum_s[WIDTH-1:0];
                     default: result_d = sum_s[WIDTH-1:0];
                  endcase
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef ALU_SEQ_DIV_EN
            if (div_q) begin
               // Restoring step: the quotient bit shifts into a_q as the dividend shifts out.
               if (rem_sh_s >= {1'b0, b_q}) begin
                  acc_d = diff_s;
                  a_d   = {a_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = rem_sh_s[WIDTH-1:0];
                  a_d   = {a_q[WIDTH-2:0], 1'b0};
               end
               step_res_s = a_d;
            end else begin
               acc_d      = acc_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
               a_d        = a_q << 1;
               b_d        = b_q >> 1;
               step_res_s = acc_d;
            end
`else
            acc_d      = acc_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
            a_d        = a_q << 1;
            b_d        = b_q >> 1;
            step_res_s = acc_d;
`endif
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = S_DONE;
               result_d = step_res_s;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      valid_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         a_q      <= {WIDTH{1'b0}};
         b_q      <= {WIDTH{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         result_q <= {WIDTH{1'b0}};
         carry_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef ALU_SEQ_DIV_EN
         div_q    <= div_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: directed vectors queue expected responses, a monitor checks them.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [63:0] req_a = 64'd0;
   logic [63:0] req_b = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [63:0] rsp_result;
   logic        rsp_carry;
   logic        busy;

   typedef struct {
      logic [63:0] res;
      logic        carry;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   alu_seq_ctrl #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] res, input logic cy, input int lat);
      exp_t e;
      bit   got;
      got = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (req_ready) got = 1'b1;
      end
      if (!got) begin
         chk("accept_timeout", 64'd0, 64'd1);
         req_valid = 1'b0;
      end else begin
         e.res   = res;
         e.carry = cy;
         e.acc   = cyc;
         e.lat   = lat;
         sb.push_back(e);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         req_op    = 4'b0010;
         req_a     = 64'hDEAD_BEEF_DEAD_BEEF;
         req_b     = 64'h0123_4567_89AB_CDEF;
      end
   endtask

   // Monitor: latency on the rising response, content on every response cycle.
   initial begin : mon
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b0;
         end else begin
            if (rsp_valid && sb.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else if (rsp_valid) begin
               if (!prev) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
               chk("result", rsp_result, sb[0].res);
               chk("carry", 64'(rsp_carry), 64'(sb[0].carry));
               chk("req_ready_in_done", 64'(req_ready), 64'd0);
               if (rsp_ready) void'(sb.pop_front());
            end
            prev = rsp_valid;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", rsp_result, 64'd0);
      chk("rst_carry", 64'(rsp_carry), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);

      issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1);
      issue(4'b0001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
      issue(4'b1010, 64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1);
      issue(4'b1000, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'h0F00_0F00, 1'b0, 1);
      issue(4'b1001, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'hFFF0_FFF0, 1'b0, 1);
      issue(4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1);
      issue(4'b0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'd1, 1'b1, 1);
      issue(4'b1111, 64'd2, 64'd3, 64'd5, 1'b0, 1);
      issue(4'b0010, 64'h1_0000_0001, 64'h1_0000_0003, 64'h4_0000_0003, 1'b0, 65);
      issue(4'b0010, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0, 65);
      issue(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 65);
`ifdef ALU_SEQ_DIV_EN
      issue(4'b0011, 64'd100, 64'd7, 64'd14, 1'b0, 65);
      issue(4'b0011, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
`else
      issue(4'b0011, 64'd100, 64'd7, 64'd107, 1'b0, 1);
      issue(4'b0011, 64'd5, 64'd0, 64'd5, 1'b0, 1);
`endif

      // Backpressure: response held for 10 cycles, request operands disturbed mid-EXEC.
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      issue(4'b0010, 64'h1234, 64'h10, 64'h12340, 1'b0, 65);
      repeat (5) @(posedge clk);
      #1;
      req_a = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("busy_in_exec", 64'(busy), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("bp_rsp_seen", 64'(seen), 64'd1);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_consume", 64'(req_ready), 64'd1);

      // Reset in the middle of a multiply.
      issue(4'b0010, 64'd12345, 64'd678, 64'd0, 1'b0, 65);
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_result", rsp_result, 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd1);
      issue(4'b0000, 64'd2, 64'd2, 64'd4, 1'b0, 1);

      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
